// File: rtl/expression_result_pkg.sv
// Shared constants, field-layout helpers and FSM state type for the result unpacker.
// The optional checksum beat is selected by the UNPACK_CHECKSUM_EN macro.
package expression_result_pkg;

   localparam int RES_W   = 90;
   localparam int NFIELDS = 18;

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   function automatic logic [2:0] field_width(input logic [4:0] idx);
      logic [4:0] m;
      m = idx % 5'd3;
      unique case (m)
         5'd0:    return 3'd4;
         5'd1:    return 3'd5;
         default: return 3'd6;
      endcase
   endfunction

   function automatic logic field_signed(input logic [4:0] idx);
      logic [4:0] m;
      m = idx % 5'd6;
      return (m >= 5'd3);
   endfunction

endpackage

// File: rtl/expression_result_unpacker_field_extend.sv
// Extends a top-aligned 4/5/6-bit field to 8 bits, sign or zero fill.
// Widths other than 4/5/6 produce zero.
module field_extend (
   input  logic [5:0] raw,
   input  logic [2:0] width,
   input  logic       is_signed,
   output logic [7:0] data
);

   logic fill;

   always_comb begin
      data = '0;
      fill = is_signed & raw[5];
      unique case (width)
         3'd4:    data = {{4{fill}}, raw[5:2]};
         3'd5:    data = {{3{fill}}, raw[5:1]};
         3'd6:    data = {{2{fill}}, raw};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/expression_result_unpacker.sv
// Serialises a 90-bit packed result word into 18 extended field beats.
// UNPACK_CHECKSUM_EN adds a trailing modular-sum beat with idx 18.
module expression_result_unpacker
   import expression_result_pkg::*;
#(
   parameter int RES_W   = 90,
   parameter int NFIELDS = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RES_W-1:0] in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_idx,
   output logic [2:0]       out_width,
   output logic             out_signed,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic [15:0]      words_done
);

   if (RES_W != 90 || NFIELDS != 18) begin : g_bad_cfg
      $error("expression_result_unpacker: RES_W must be 90 and NFIELDS 18");
   end

   localparam logic [4:0] LAST_FIELD = 5'(NFIELDS - 1);

   state_t           state;
   logic [RES_W-1:0] shift;
   logic [RES_W-1:0] src;
   logic [4:0]       nidx;
   logic [2:0]       nwidth;
   logic             nsigned;
   logic [7:0]       ext_data;
   logic             accept;
   logic             fire;

`ifdef UNPACK_CHECKSUM_EN
   logic [7:0] sum;
`endif

   assign accept = (state == IDLE) && in_valid && in_ready;
   assign fire   = out_valid && out_ready;

   // Next field always comes from the top of the (re)loaded shift register.
   always_comb begin
      src     = (state == IDLE) ? in_y : (shift << out_width);
      nidx    = (state == IDLE) ? 5'd0 : out_idx + 5'd1;
      nwidth  = field_width(nidx);
      nsigned = field_signed(nidx);
   end

   field_extend u_ext (
      .raw       (src[RES_W-1 -: 6]),
      .width     (nwidth),
      .is_signed (nsigned),
      .data      (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift      <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_width  <= '0;
         out_signed <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         words_done <= '0;
`ifdef UNPACK_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  in_ready   <= 1'b0;
                  state      <= EMIT;
                  shift      <= src;
                  out_valid  <= 1'b1;
                  out_idx    <= nidx;
                  out_width  <= nwidth;
                  out_signed <= nsigned;
                  out_data   <= ext_data;
                  out_last   <= 1'b0;
`ifdef UNPACK_CHECKSUM_EN
                  sum        <= '0;
`endif
               end
            end
            EMIT: begin
               if (fire) begin
                  if (out_last) begin
                     state      <= IDLE;
                     in_ready   <= 1'b1;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     words_done <= words_done + 16'd1;
`ifdef UNPACK_CHECKSUM_EN
                  end else if (out_idx == LAST_FIELD) begin
                     out_idx    <= nidx;
                     out_width  <= '0;
                     out_signed <= 1'b0;
                     out_data   <= sum + out_data;
                     out_last   <= 1'b1;
`endif
                  end else begin
                     shift      <= src;
                     out_idx    <= nidx;
                     out_width  <= nwidth;
                     out_signed <= nsigned;
                     out_data   <= ext_data;
`ifdef UNPACK_CHECKSUM_EN
                     out_last   <= 1'b0;
                     sum        <= sum + out_data;
`else
                     out_last   <= (nidx == LAST_FIELD);
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_expression_result_unpacker.sv
// Directed-vector bench for expression_result_unpacker.
// Honours UNPACK_CHECKSUM_EN to expect the extra checksum beat.
module tb_expression_result_unpacker;

`ifdef UNPACK_CHECKSUM_EN
   localparam int NB = 19;
`else
   localparam int NB = 18;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [89:0] in_y;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_idx;
   logic [2:0]  out_width;
   logic        out_signed;
   logic [7:0]  out_data;
   logic        out_last;
   logic [15:0] words_done;

   int          n_checks;
   int          n_errs;
   int          wd;
   logic [7:0]  got [0:18];

   expression_result_unpacker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_y       (in_y),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_width  (out_width),
      .out_signed (out_signed),
      .out_data   (out_data),
      .out_last   (out_last),
      .words_done (words_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int fw(input int k);
      return (k % 3 == 0) ? 4 : (k % 3 == 1) ? 5 : 6;
   endfunction

   function automatic bit fs(input int k);
      return (k % 6) >= 3;
   endfunction

   function automatic logic [7:0] exp_field(input logic [89:0] y, input int i);
      int pos;
      int w;
      logic [89:0] t;
      logic [7:0] r;
      pos = 90;
      for (int k = 0; k < i; k++) pos -= fw(k);
      w = fw(i);
      t = y >> (pos - w);
      r = '0;
      for (int b = 0; b < w; b++) r[b] = t[b];
      if (fs(i) && t[w-1])
         for (int b = w; b < 8; b++) r[b] = 1'b1;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_word(input logic [89:0] y, input bit toggle,
                           input int abort_at);
      int n;
      int beat;
      int cyc;
      bit fired;
      logic [7:0] sum;
      logic [7:0] ed;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         check("in_ready_wait", 32'(in_ready), 32'd1);
         return;
      end
      in_valid  = 1'b1;
      in_y      = y;
      out_ready = toggle ? 1'b0 : 1'b1;
      tick();
      in_valid = 1'b0;
      beat = 0;
      cyc  = 0;
      sum  = '0;
      while (beat < NB && cyc < 100) begin
         check("in_ready_busy", 32'(in_ready), 32'd0);
         check("out_valid", 32'(out_valid), 32'd1);
         check("out_idx", 32'(out_idx), 32'(beat));
         if (beat < 18) begin
            ed = exp_field(y, beat);
            check("out_width", 32'(out_width), 32'(fw(beat)));
            check("out_signed", 32'(out_signed), 32'(fs(beat)));
            check("out_data", 32'(out_data), 32'(ed));
            check("out_last", 32'(out_last), 32'(beat == NB - 1));
         end else begin
            check("ck_width", 32'(out_width), 32'd0);
            check("ck_signed", 32'(out_signed), 32'd0);
            check("ck_data", 32'(out_data), 32'(sum));
            check("ck_last", 32'(out_last), 32'd1);
         end
         got[beat] = out_data;
         if (beat == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_valid", 32'(out_valid), 32'd0);
            check("abort_ready", 32'(in_ready), 32'd0);
            check("abort_idx", 32'(out_idx), 32'd0);
            tick();
            rst_n     = 1'b1;
            out_ready = 1'b1;
            tick();
            check("post_abort_ready", 32'(in_ready), 32'd1);
            check("post_abort_valid", 32'(out_valid), 32'd0);
            check("post_abort_done", 32'(words_done), 32'd0);
            wd = 0;
            return;
         end
         fired = out_ready;
         tick();
         cyc++;
         if (fired) begin
            if (beat < 18) sum = sum + exp_field(y, beat);
            beat++;
         end
         if (toggle) out_ready = ~out_ready;
      end
      check("word_cycles", 32'(cyc), toggle ? 32'(2 * NB) : 32'(NB));
      wd++;
      check("end_valid", 32'(out_valid), 32'd0);
      check("end_in_ready", 32'(in_ready), 32'd1);
      check("words_done", 32'(words_done), 32'(wd[15:0]));
      out_ready = 1'b1;
   endtask

   initial begin
      logic [89:0] ones;
      logic [89:0] mixed;
      n_checks  = 0;
      n_errs    = 0;
      wd        = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_y      = '0;
      out_ready = 1'b0;
      ones      = '1;
      mixed     = 90'h3_AB5A_5AC3_C30F_0FF0_F012_34;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_width", 32'(out_width), 32'd0);
      check("rst_signed", 32'(out_signed), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_words", 32'(words_done), 32'd0);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         check("idle_in_ready", 32'(in_ready), 32'd1);
         check("idle_out_valid", 32'(out_valid), 32'd0);
         tick();
      end
      check("idle_words", 32'(words_done), 32'd0);

      run_word(90'hA << 86, 1'b0, -1);
      check("y0_beat0", 32'(got[0]), 32'h0A);
      check("y0_beat1", 32'(got[1]), 32'h00);

      run_word(90'h1 << 74, 1'b0, -1);
      check("y3_beat3", 32'(got[3]), 32'hF8);
      check("y3_beat2", 32'(got[2]), 32'h00);

      run_word(ones, 1'b0, -1);
      check("ones_b0", 32'(got[0]), 32'h0F);
      check("ones_b1", 32'(got[1]), 32'h1F);
      check("ones_b2", 32'(got[2]), 32'h3F);
      check("ones_b3", 32'(got[3]), 32'hFF);
      check("ones_b17", 32'(got[17]), 32'hFF);

      run_word(mixed, 1'b0, -1);
      run_word(ones, 1'b1, -1);
      run_word(mixed, 1'b0, 9);
      run_word(90'h1 << 74, 1'b0, -1);
      check("after_abort_b3", 32'(got[3]), 32'hF8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
